// File: rtl/sel_scan_ctrl_pkg.sv
// Shared constants and state encoding for the selector scan sequencer.
// Sized for the 8-way, 4-bit selector.
package sel_scan_ctrl_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/sel_next_chan.sv
// Picks the lowest enabled channel strictly above cur (or the lowest overall when from_start).
// Purely combinational, so there is no latency and no backpressure.
module sel_next_chan
    import sel_scan_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              from_start,
    output logic [CH_W-1:0]   next_chan,
    output logic              found
);

    // Scan from the top down so that the lowest qualifying bit is the last one written.
    always_comb begin
        next_chan = '0;
        found     = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (CH_W'(i) > cur))) begin
                next_chan = CH_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sel_scan_ctrl.sv
// Steps sel over the masked channels, waits SETTLE_CYCLES, then offers each sampled word on a valid/ready port.
// The first word appears SETTLE_CYCLES+1 cycles after start; a held word stalls the scan until it is accepted.
module sel_scan_ctrl
    import sel_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cont_mode,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic [CH_W-1:0]   sel,
    input  logic [DATA_W-1:0] mux_data,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic              cont_q;
    logic [CNT_W-1:0]  cnt;

    logic [CH_W-1:0]   first_chan;
    logic              first_found;
    logic [CH_W-1:0]   nxt_chan;
    logic              nxt_found;

    // First channel of a fresh pass, taken from the live mask at each latch point.
    sel_next_chan u_first (
        .mask       (chan_mask),
        .cur        (sel),
        .from_start (1'b1),
        .next_chan  (first_chan),
        .found      (first_found)
    );

    sel_next_chan u_next (
        .mask       (mask_q),
        .cur        (sel),
        .from_start (1'b0),
        .next_chan  (nxt_chan),
        .found      (nxt_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            cont_q    <= 1'b0;
            cnt       <= '0;
            sel       <= '0;
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // sel is deliberately left alone so the selector path does not glitch.
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (first_found) begin
                                mask_q <= chan_mask;
                                cont_q <= cont_mode;
                                sel    <= first_chan;
                                cnt    <= CNT_LOAD;
                                state  <= ST_SETTLE;
                                busy   <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == '0) begin
                            out_data  <= mux_data;
                            out_chan  <= sel;
                            out_valid <= 1'b1;
                            state     <= ST_OUTPUT;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_OUTPUT: begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                            if (nxt_found) begin
                                sel   <= nxt_chan;
                                cnt   <= CNT_LOAD;
                                state <= ST_SETTLE;
                            end else if (cont_q && first_found) begin
                                mask_q <= chan_mask;
                                cont_q <= cont_mode;
                                sel    <= first_chan;
                                cnt    <= CNT_LOAD;
                                state  <= ST_SETTLE;
                            end else begin
                                // An empty mask at the wrap ends a continuous scan like a one-shot pass.
                                if (cont_q) begin
                                    mask_q <= chan_mask;
                                    cont_q <= cont_mode;
                                end
                                done  <= 1'b1;
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Directed bench for sel_scan_ctrl: one-shot, backpressure, empty mask, continuous, abort, async reset.
module tb_sel_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       cont_mode;
    logic [7:0] chan_mask;
    logic [2:0] sel;
    logic [3:0] mux_data;
    logic [3:0] out_data;
    logic [2:0] out_chan;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_err    = 0;

    logic [6:0] words[$];
    int first_v, last_v, done_cnt, done_at, busy_seen;

    sel_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cont_mode (cont_mode),
        .chan_mask (chan_mask),
        .sel       (sel),
        .mux_data  (mux_data),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Selector model: channel i presents i+3.
    assign mux_data = {1'b0, sel} + 4'h3;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, releasing start/abort after the first edge and recording words and done pulses.
    task automatic collect(input int n);
        words.delete();
        first_v   = -1;
        last_v    = -1;
        done_cnt  = 0;
        done_at   = -1;
        busy_seen = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            if (out_valid) begin
                words.push_back({out_chan, out_data});
                if (first_v < 0) first_v = i;
                last_v = i;
            end
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (busy) busy_seen = 1;
        end
    endtask

    logic [6:0] exp_w[4];
    logic [6:0] w;
    int         lat;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cont_mode = 1'b0;
        chan_mask = 8'h00;
        out_ready = 1'b1;
        step();
        step();
        chk("reset_outputs", {29'd0, out_valid, busy, done}, 32'd0);
        chk("reset_sel_data", {21'd0, sel, out_data, out_chan}, 32'd0);
        reset = 1'b0;
        step();

        // One-shot scan over channels 0,2,5,7.
        chan_mask = 8'b1010_0101;
        start     = 1'b1;
        collect(20);
        exp_w = '{{3'd0, 4'h3}, {3'd2, 4'h5}, {3'd5, 4'h8}, {3'd7, 4'hA}};
        chk("oneshot_latency", 32'(first_v), 32'd3);
        chk("oneshot_count", 32'(words.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            w = (k < words.size()) ? words[k] : 7'h7f;
            chk($sformatf("oneshot_word%0d", k), {25'd0, w}, {25'd0, exp_w[k]});
        end
        chk("oneshot_done_cnt", 32'(done_cnt), 32'd1);
        chk("oneshot_done_at", 32'(done_at), 32'(last_v + 1));
        chk("oneshot_busy_after", {31'd0, busy}, 32'd0);

        // Backpressure on a single channel.
        chan_mask = 8'h01;
        out_ready = 1'b0;
        start     = 1'b1;
        lat       = 0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            step();
            start = 1'b0;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {21'd0, out_valid, out_chan, out_data, sel},
                {21'd0, 1'b1, 3'd0, 4'h3, 3'd0});
            if (i < 4) step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_done", {29'd0, done, out_valid, busy}, {29'd0, 3'b100});
        step();
        chk("bp_done_pulse", {31'd0, done}, 32'd0);

        // Empty mask: immediate done, never busy.
        chan_mask = 8'h00;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("empty_done", {29'd0, done, busy, out_valid}, {29'd0, 3'b100});
        step();
        chk("empty_after", {29'd0, done, busy, out_valid}, 32'd0);

        // Continuous mode with a mask change during the first pass.
        cont_mode = 1'b1;
        chan_mask = 8'h81;
        start     = 1'b1;
        step();
        start     = 1'b0;
        chan_mask = 8'h02;
        collect(9);
        chk("cont_count", 32'(words.size()), 32'd3);
        exp_w = '{{3'd0, 4'h3}, {3'd7, 4'hA}, {3'd1, 4'h4}, 7'h00};
        for (int k = 0; k < 3; k++) begin
            w = (k < words.size()) ? words[k] : 7'h7f;
            chk($sformatf("cont_word%0d", k), {25'd0, w}, {25'd0, exp_w[k]});
        end
        chk("cont_no_done", 32'(done_cnt), 32'd0);
        chk("cont_busy", {31'd0, busy}, 32'd1);
        abort     = 1'b1;
        cont_mode = 1'b0;
        step();
        abort = 1'b0;
        chk("cont_abort", {30'd0, busy, out_valid}, 32'd0);

        // Abort during the settle of channel 2, with a competing start.
        chan_mask = 8'h05;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_w0", {24'd0, out_valid, out_chan, out_data}, {24'd0, 1'b1, 3'd0, 4'h3});
        step();
        chk("abort_pre", {27'd0, sel, busy, out_valid}, {27'd0, 3'd2, 1'b1, 1'b0});
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle", {29'd0, out_valid, done, busy}, 32'd0);
        step();
        chk("abort_no_start", {27'd0, sel, busy, done}, {27'd0, 3'd2, 2'b00});

        // Asynchronous reset while a word is held.
        chan_mask = 8'h08;
        out_ready = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("arst_pre", {24'd0, out_valid, out_chan, out_data}, {24'd0, 1'b1, 3'd3, 4'h6});
        #2;
        reset = 1'b1;
        #1;
        chk("arst_now", {20'd0, out_valid, sel, busy, done, out_data, out_chan}, 32'd0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        chk("arst_after", {30'd0, busy, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
